sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Three-client round-robin arbiter between the PlayStation core's memory masters (CPU, GPU, CD/SPU DMA) and the single-request 128-bit SDRAM controller port.
- Serialises the clients' requests onto one write/read/adrs/din/enable/burst interface.
- Routes the controller's ack and read data back to the granted client.
- Adds a watchdog so a lost ack cannot hang the core.

Parameters:
- ADRS_W, 25, SDRAM address width (controller word address).
- DATA_W, 128, data bus width; the byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 1024, maximum cycles spent waiting for the controller ack before abort.

Ports:
- m_clock  in  1  single clock, the same clock as the SDRAM controller port.
- p_reset_n  in  1  asynchronous, active-low reset.
- cN_req  in  1  (N=0,1,2) level request; held until cN_ack.
- cN_we  in  1  1=write, 0=read; held with cN_req.
- cN_adrs  in  ADRS_W  request address; held with cN_req.
- cN_din  in  DATA_W  write data; held with cN_req.
- cN_enable  in  DATA_W/8  byte enables for writes; held with cN_req.
- cN_burst  in  4  burst code; passed through unchanged.
- cN_ack  out  1  one-cycle completion pulse to client N.
- rd_data  out  DATA_W  read data, shared by all clients; valid in the cN_ack cycle and held until the next ack.
- sdram_write, sdram_read  out  1  one-cycle command pulses to the controller.
- sdram_adrs, sdram_din, sdram_enable, sdram_burst  out  ADRS_W/DATA_W/DATA_W/8/4  registered command fields; stable from the command pulse until the ack.
- sdram_dout  in  DATA_W  controller read data; valid in the sdram_ack cycle.
- sdram_ack  in  1  controller completion pulse.
- err_timeout  out  1  sticky flag, set when a request is aborted; cleared only by reset.
- grant_id  out  2  index of the current/last granted client, for debug.

Behaviour:
- Reset (async, p_reset_n=0):
  - state=IDLE.
  - All cN_ack, sdram_write and sdram_read are 0.
  - sdram_adrs, sdram_din, sdram_enable, sdram_burst and rd_data are 0.
  - err_timeout=0.
  - The round-robin pointer last=2, so client 0 wins the first arbitration. grant_id=2.
- Reset mid-operation aborts immediately. No ack is issued for the lost request. A late sdram_ack after release is ignored because state=IDLE.
- State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any cN_req=1, pick the first requesting client in the order last+1, last+2, last+3 (mod 3).
  - Latch that client's we/adrs/din/enable/burst into the sdram_* registers.
  - Set grant_id=N and last=N, then go to ISSUE.
  - If no client requests, stay in IDLE.
- ISSUE (one cycle):
  - sdram_write=we or sdram_read=!we for exactly this one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Command pulses are 0. The timeout counter increments every cycle.
  - If sdram_ack=1: register rd_data<=sdram_dout (for writes too; the content is don't-care), then go to DONE.
  - Otherwise, if the counter reaches TIMEOUT_CYC-1: set err_timeout=1, set rd_data<=0, then go to DONE.
  - If ack and timeout coincide, the ack wins and err_timeout is not set.
- DONE (one cycle): cN_ack=1 for the granted client only, then go to IDLE.
- Latency, with the controller ack arriving k cycles after the command pulse (k>=1):
  - The command pulse appears 1 cycle after the cycle in which req is sampled in IDLE.
  - cN_ack appears k+1 cycles after the command pulse.
  - Minimum request-to-ack total is k+2 cycles.
- Client rule:
  - A client must drop req (or present a new request) at the clock edge that ends its ack cycle.
  - req still high in the following IDLE cycle is treated as a new request.
  - Because last=N, a client that re-requests back-to-back loses to any other pending client.
- sdram_ack outside WAIT (stale, after a timeout) is ignored; it produces no cN_ack and no rd_data update.
- cN_req changes while that client is not granted have no effect until the next IDLE cycle.
- Only one command is ever outstanding. sdram_write and sdram_read are never high together, and never high in more than one consecutive cycle.
- Timeout counter width is ceil(log2(TIMEOUT_CYC)). It saturates at TIMEOUT_CYC-1 and never wraps.

Test Plan:
- Single read: c1 read, adrs=0x0012340, controller acks 3 cycles after sdram_read with dout=0x...DEADBEEF -> sdram_read is a single pulse carrying adrs 0x0012340; c1_ack pulses once 4 cycles after the pulse; rd_data=0x...DEADBEEF; c0_ack and c2_ack stay 0.
- Write pass-through: c2 write, din=0x0123...CDEF, enable=0x00FF, burst=1 -> sdram_write is one pulse with identical din/enable/burst, held until ack; c2_ack follows.
- Contention: c0, c1 and c2 all raise req in the same cycle and re-request immediately after each ack -> grant order 0,1,2,0,1,2; grant_id follows that order; one command outstanding at a time.
- Fairness: c0 re-requests continuously while c2 requests once -> c2 is served immediately after c0's first transaction, not starved.
- Timeout: TIMEOUT_CYC=16, controller never acks -> c0_ack pulses 16 cycles after WAIT entry; rd_data=0; err_timeout=1 and stays 1; a later stray sdram_ack produces no cN_ack.
- Reset mid-WAIT: assert p_reset_n=0 during WAIT, release, then send a stray sdram_ack -> all outputs at reset values, no cN_ack, next c0 request granted first.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter from three memory masters onto one SDRAM port.
// Ports: cN_* client request/ack, sdram_* controller port, rd_data, err_timeout, grant_id.
module sdram_port_arbiter #(
  parameter int ADRS_W      = 25,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                m_clock,
  input  logic                p_reset_n,

  input  logic                c0_req,
  input  logic                c0_we,
  input  logic [ADRS_W-1:0]   c0_adrs,
  input  logic [DATA_W-1:0]   c0_din,
  input  logic [DATA_W/8-1:0] c0_enable,
  input  logic [3:0]          c0_burst,
  output logic                c0_ack,

  input  logic                c1_req,
  input  logic                c1_we,
  input  logic [ADRS_W-1:0]   c1_adrs,
  input  logic [DATA_W-1:0]   c1_din,
  input  logic [DATA_W/8-1:0] c1_enable,
  input  logic [3:0]          c1_burst,
  output logic                c1_ack,

  input  logic                c2_req,
  input  logic                c2_we,
  input  logic [ADRS_W-1:0]   c2_adrs,
  input  logic [DATA_W-1:0]   c2_din,
  input  logic [DATA_W/8-1:0] c2_enable,
  input  logic [3:0]          c2_burst,
  output logic                c2_ack,

  output logic [DATA_W-1:0]   rd_data,

  output logic                sdram_write,
  output logic                sdram_read,
  output logic [ADRS_W-1:0]   sdram_adrs,
  output logic [DATA_W-1:0]   sdram_din,
  output logic [DATA_W/8-1:0] sdram_enable,
  output logic [3:0]          sdram_burst,
  input  logic [DATA_W-1:0]   sdram_dout,
  input  logic                sdram_ack,

  output logic                err_timeout,
  output logic [1:0]          grant_id
);

  localparam int EN_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [1:0]         r_last;
  logic               r_we;
  logic [ADRS_W-1:0]  r_adrs;
  logic [DATA_W-1:0]  r_din;
  logic [EN_W-1:0]    r_en;
  logic [3:0]         r_burst;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_err;

  logic [2:0]         w_req;
  logic               w_gnt_vld;
  logic [1:0]         w_gnt_id;
  logic               w_timeout;
  logic               w_cmd_wr;
  logic               w_cmd_rd;
  logic               w_done;

  logic               w_we   [3];
  logic [ADRS_W-1:0]  w_adrs [3];
  logic [DATA_W-1:0]  w_din  [3];
  logic [EN_W-1:0]    w_en   [3];
  logic [3:0]         w_bst  [3];

  assign w_req = {c2_req, c1_req, c0_req};

  assign w_we[0]   = c0_we;
  assign w_we[1]   = c1_we;
  assign w_we[2]   = c2_we;
  assign w_adrs[0] = c0_adrs;
  assign w_adrs[1] = c1_adrs;
  assign w_adrs[2] = c2_adrs;
  assign w_din[0]  = c0_din;
  assign w_din[1]  = c1_din;
  assign w_din[2]  = c2_din;
  assign w_en[0]   = c0_enable;
  assign w_en[1]   = c1_enable;
  assign w_en[2]   = c2_enable;
  assign w_bst[0]  = c0_burst;
  assign w_bst[1]  = c1_burst;
  assign w_bst[2]  = c2_burst;

  // Search starts just after the last winner, so a client that
  // re-requests back-to-back yields to anyone else waiting.
  always_comb begin
    w_gnt_vld = |w_req;
    w_gnt_id  = r_last;
    unique case (r_last)
      2'd0: w_gnt_id = w_req[1] ? 2'd1 :
                       w_req[2] ? 2'd2 :
                       w_req[0] ? 2'd0 : r_last;
      2'd1: w_gnt_id = w_req[2] ? 2'd2 :
                       w_req[0] ? 2'd0 :
                       w_req[1] ? 2'd1 : r_last;
      default: w_gnt_id = w_req[0] ? 2'd0 :
                          w_req[1] ? 2'd1 :
                          w_req[2] ? 2'd2 : r_last;
    endcase
  end

  assign w_timeout = (r_cnt == CNT_MAX);

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_cmd_wr = 1'b0;
    w_cmd_rd = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_cmd_wr = r_we;
        w_cmd_rd = !r_we;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (sdram_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_last    <= 2'd2;
      r_we      <= 1'b0;
      r_adrs    <= '0;
      r_din     <= '0;
      r_en      <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_last  <= w_gnt_id;
            r_we    <= w_we[w_gnt_id];
            r_adrs  <= w_adrs[w_gnt_id];
            r_din   <= w_din[w_gnt_id];
            r_en    <= w_en[w_gnt_id];
            r_burst <= w_bst[w_gnt_id];
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
        end
        ST_WAIT: begin
          // Saturate rather than wrap.
          if (!w_timeout) r_cnt <= r_cnt + CNT_W'(1);
          // Ack beats a coincident timeout.
          if (sdram_ack) begin
            r_rd_data <= sdram_dout;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_rd_data <= '0;
          end
        end
        ST_DONE: begin
        end
      endcase
    end
  end

  assign c0_ack       = w_done && (r_last == 2'd0);
  assign c1_ack       = w_done && (r_last == 2'd1);
  assign c2_ack       = w_done && (r_last == 2'd2);
  assign rd_data      = r_rd_data;
  assign sdram_write  = w_cmd_wr;
  assign sdram_read   = w_cmd_rd;
  assign sdram_adrs   = r_adrs;
  assign sdram_din    = r_din;
  assign sdram_enable = r_en;
  assign sdram_burst  = r_burst;
  assign err_timeout  = r_err;
  assign grant_id     = r_last;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter.
// Ports: drives all three clients and a simple controller model.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 128;
  localparam int EW = DW / 8;

  logic          m_clock = 1'b0;
  logic          p_reset_n = 1'b0;

  logic          c0_req = 0, c1_req = 0, c2_req = 0;
  logic          c0_we = 0, c1_we = 0, c2_we = 0;
  logic [AW-1:0] c0_adrs = '0, c1_adrs = '0, c2_adrs = '0;
  logic [DW-1:0] c0_din = '0, c1_din = '0, c2_din = '0;
  logic [EW-1:0] c0_enable = '0, c1_enable = '0, c2_enable = '0;
  logic [3:0]    c0_burst = '0, c1_burst = '0, c2_burst = '0;
  logic          c0_ack, c1_ack, c2_ack;

  logic [DW-1:0] rd_data;
  logic          sdram_write, sdram_read;
  logic [AW-1:0] sdram_adrs;
  logic [DW-1:0] sdram_din;
  logic [EW-1:0] sdram_enable;
  logic [3:0]    sdram_burst;
  logic [DW-1:0] sdram_dout = '0;
  logic          sdram_ack;
  logic          err_timeout;
  logic [1:0]    grant_id;

  logic          ack_dir = 1'b0;
  logic          ack_auto = 1'b0;
  logic          auto_en = 1'b0;
  logic          prev_cmd = 1'b0;
  int            viol = 0;

  int            n_chk = 0;
  int            n_fail = 0;

  logic [2:0]    ackv;
  int            ng;
  int            gid_q [6];
  int            gnt_q [6];

  assign sdram_ack = ack_dir | ack_auto;
  assign ackv = {c2_ack, c1_ack, c0_ack};

  sdram_port_arbiter #(
    .ADRS_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .m_clock(m_clock), .p_reset_n(p_reset_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_adrs(c0_adrs),
    .c0_din(c0_din), .c0_enable(c0_enable),
    .c0_burst(c0_burst), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_adrs(c1_adrs),
    .c1_din(c1_din), .c1_enable(c1_enable),
    .c1_burst(c1_burst), .c1_ack(c1_ack),
    .c2_req(c2_req), .c2_we(c2_we), .c2_adrs(c2_adrs),
    .c2_din(c2_din), .c2_enable(c2_enable),
    .c2_burst(c2_burst), .c2_ack(c2_ack),
    .rd_data(rd_data),
    .sdram_write(sdram_write), .sdram_read(sdram_read),
    .sdram_adrs(sdram_adrs), .sdram_din(sdram_din),
    .sdram_enable(sdram_enable), .sdram_burst(sdram_burst),
    .sdram_dout(sdram_dout), .sdram_ack(sdram_ack),
    .err_timeout(err_timeout), .grant_id(grant_id)
  );

  always #5 m_clock = ~m_clock;

  // Controller model: ack one cycle after each command pulse.
  always @(posedge m_clock)
    ack_auto <= auto_en && (sdram_write || sdram_read) && !ack_auto;

  // Command protocol watcher.
  always @(negedge m_clock) begin
    if (sdram_write && sdram_read) viol++;
    if ((sdram_write || sdram_read) && prev_cmd) viol++;
    prev_cmd = sdram_write || sdram_read;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  function automatic int ack_id(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    // Reset values
    step();
    step();
    chk("rst_ack", 128'(ackv), 0);
    chk("rst_cmd", 128'({sdram_write, sdram_read}), 0);
    chk("rst_adrs", 128'(sdram_adrs), 0);
    chk("rst_din", sdram_din, 0);
    chk("rst_en_bst", 128'({sdram_enable, sdram_burst}), 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_err", 128'(err_timeout), 0);
    chk("rst_gid", 128'(grant_id), 2);
    p_reset_n = 1'b1;
    step();

    // Single read, k=3
    c1_req = 1; c1_we = 0; c1_adrs = 25'h0012340;
    step();
    chk("rd_pulse", 128'({sdram_read, sdram_write}), 2'b10);
    chk("rd_adrs", 128'(sdram_adrs), 25'h0012340);
    chk("rd_gid", 128'(grant_id), 1);
    step();
    chk("rd_once", 128'(sdram_read), 0);
    step();
    step();
    ack_dir = 1; sdram_dout = 128'hDEADBEEF;
    step();
    ack_dir = 0;
    chk("rd_ack", 128'(ackv), 3'b010);
    chk("rd_data", rd_data, 128'hDEADBEEF);
    c1_req = 0;
    step();
    chk("rd_ack_end", 128'(ackv), 0);

    // Write pass-through, k=1
    c2_req = 1; c2_we = 1; c2_adrs = 25'h0000055;
    c2_din = 128'h0123456789ABCDEF0123456789ABCDEF;
    c2_enable = 16'h00FF; c2_burst = 4'd1;
    step();
    chk("wr_pulse", 128'({sdram_write, sdram_read}), 2'b10);
    chk("wr_din", sdram_din, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("wr_en_bst", 128'({sdram_enable, sdram_burst}), {16'h00FF, 4'd1});
    chk("wr_adrs", 128'(sdram_adrs), 25'h55);
    step();
    c2_din = '0; c2_enable = '0;
    ack_dir = 1;
    chk("wr_hold", 128'({sdram_write, sdram_enable}), {1'b0, 16'h00FF});
    chk("wr_hold_din", sdram_din, 128'h0123456789ABCDEF0123456789ABCDEF);
    step();
    ack_dir = 0;
    chk("wr_ack", 128'(ackv), 3'b100);
    c2_req = 0;
    step();

    // Contention: all three held high
    auto_en = 1; sdram_dout = 128'h5A;
    c0_req = 1; c1_req = 1; c2_req = 1;
    c0_we = 0; c1_we = 0; c2_we = 0;
    ng = 0;
    for (int cyc = 0; cyc < 80 && ng < 6; cyc++) begin
      step();
      if (|ackv) begin
        gnt_q[ng] = ack_id(ackv);
        gid_q[ng] = int'(grant_id);
        ng++;
        if (ng == 6) begin
          c0_req = 0; c1_req = 0; c2_req = 0;
        end
      end
    end
    chk("cont_count", 128'(ng), 6);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("cont_gnt%0d", i), 128'(gnt_q[i]), 128'(i % 3));
      chk($sformatf("cont_gid%0d", i), 128'(gid_q[i]), 128'(i % 3));
    end
    chk("cont_viol", 128'(viol), 0);
    step();

    // Fairness: c0 continuous, c2 once
    c0_req = 1;
    step();
    c2_req = 1;
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 3; cyc++) begin
      step();
      if (|ackv) begin
        gnt_q[ng] = ack_id(ackv);
        if (c2_ack) c2_req = 0;
        ng++;
        if (ng == 3) c0_req = 0;
      end
    end
    chk("fair_count", 128'(ng), 3);
    chk("fair_g0", 128'(gnt_q[0]), 0);
    chk("fair_g1", 128'(gnt_q[1]), 2);
    chk("fair_g2", 128'(gnt_q[2]), 0);
    c0_req = 0; c2_req = 0;
    auto_en = 0;
    step();
    step();

    // Timeout, TIMEOUT_CYC=16
    chk("to_rd_before", rd_data, 128'h5A);
    c0_req = 1; c0_we = 0; c0_adrs = 25'h777;
    step();
    chk("to_pulse", 128'(sdram_read), 1);
    step();
    repeat (15) step();
    chk("to_early", 128'({ackv, err_timeout}), 0);
    step();
    chk("to_ack", 128'(ackv), 3'b001);
    chk("to_rd0", rd_data, 0);
    chk("to_err", 128'(err_timeout), 1);
    c0_req = 0;
    step();
    ack_dir = 1; sdram_dout = 128'hFFFF;
    step();
    ack_dir = 0;
    chk("stray_ack", 128'(ackv), 0);
    chk("stray_rd", rd_data, 0);
    step();
    chk("stray_ack2", 128'(ackv), 0);
    chk("err_sticky", 128'(err_timeout), 1);

    // Reset during WAIT
    c1_req = 1; c1_we = 0; c1_adrs = 25'h99;
    step();
    step();
    step();
    p_reset_n = 0;
    #1;
    chk("mr_gid", 128'(grant_id), 2);
    chk("mr_err", 128'(err_timeout), 0);
    chk("mr_rd", rd_data, 0);
    chk("mr_adrs", 128'(sdram_adrs), 0);
    chk("mr_ack", 128'({ackv, sdram_read, sdram_write}), 0);
    c1_req = 0;
    step();
    p_reset_n = 1;
    step();
    ack_dir = 1;
    step();
    ack_dir = 0;
    chk("mr_stray", 128'(ackv), 0);
    chk("mr_stray_rd", rd_data, 0);
    auto_en = 1; sdram_dout = 128'h1234;
    c0_req = 1; c0_we = 0; c0_adrs = 25'h42;
    c1_req = 1;
    step();
    chk("mr_gnt0", 128'(grant_id), 0);
    chk("mr_cmd", 128'({sdram_read, sdram_adrs}), {1'b1, 25'h42});
    step();
    step();
    chk("mr_c0ack", 128'(ackv), 3'b001);
    chk("mr_c0rd", rd_data, 128'h1234);
    c0_req = 0; c1_req = 0;
    auto_en = 0;
    step();
    step();
    chk("final_viol", 128'(viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
